ramp_init_seq: RTL and testbench
================================

// Module: ramp_init_seq
// PURPOSE
//  Parametrised single-port synchronous RAM for the cache test path. Read data is registered.
//  A hardware init sequencer fills a programmable prefix of the array after reset,
//  writing one word per clock.
//  Request/ack handshake; busy flags the init window. Sits behind the cache as backing store.
// PARAMETERS
//  DATA_WIDTH  8    word width in bits
//  ADDR_WIDTH  11   address bits; RAM_DEPTH = 1<<ADDR_WIDTH
//  INIT_WORDS  62   words filled after reset (addresses 0..INIT_WORDS-1); clamped to RAM_DEPTH
//  INIT_BASE   10   value written to address 0; address i gets INIT_BASE+i
// PORTS
//  clk      in   1           rising-edge clock
//  reset    in   1           asynchronous, active-high reset
//  req      in   1           access request, sampled on posedge clk
//  wr       in   1           1=write, 0=read; qualified by req
//  addr     in   ADDR_WIDTH  access address
//  din      in   DATA_WIDTH  write data
//  ack      out  1           one-cycle pulse: request of previous cycle completed
//  dout     out  DATA_WIDTH  registered read data, valid when ack follows a read
//  busy     out  1           init sequencer active; requests ignored
//  perr     out  1           (RAMP_PARITY_EN only) parity mismatch on the read being acked
//  inj_perr in   1           (RAMP_PARITY_EN only) store inverted parity on this write
// BEHAVIOUR
//  Reset (async assert): state=INIT, cnt=0, ack=0, dout=0, busy=1, perr=0.
//   Array contents are not cleared by reset.
//  FSM INIT: each clk writes mem[cnt] = (INIT_BASE+cnt) mod 2^DATA_WIDTH, then cnt++.
//   After the write of INIT_WORDS-1, go to IDLE; busy falls on that same edge.
//   INIT_WORDS=0: go to IDLE on first clk after reset release; no writes.
//  INIT: req is ignored entirely; no ack, no array access, no dout change.
//  IDLE, req&&wr at edge N: mem[addr]<=din at edge N; ack=1 after edge N+1 is not used --
//   ack=1 for the cycle following edge N; dout holds its previous value.
//  IDLE, req&&!wr at edge N: dout<=mem[addr] at edge N; ack=1 for the following cycle.
//   Read-to-data latency is 1 clk.
//  req low: ack=0 next cycle; dout holds.
//  Back-to-back requests every cycle: full throughput, one ack per request.
//  A read of an address written on the previous edge returns the new data.
//  Address is always in range; no wrap logic needed. Init sum wraps mod 2^DATA_WIDTH
//   (e.g. DATA_WIDTH=8, INIT_BASE=250: addr 6 holds 0).
//  Reset mid-init or mid-access: the in-flight request is dropped with no ack.
//   Init restarts at cnt=0; prior array writes persist except init region overwrite.
// CONFIGURATION
//  RAMP_PARITY_EN defined: array is DATA_WIDTH+1 wide and holds even parity of data.
//   Init writes correct parity. Write stores ^din, inverted if inj_perr=1.
//   Read sets perr=1 with ack when stored parity != ^data; perr=0 otherwise.
//  RAMP_PARITY_EN undefined: no perr/inj_perr ports; array is DATA_WIDTH wide.
// TESTING
//  Release reset, defaults -> busy high exactly 62 clks then low; read addr 0/61 -> 10/71.
//  Read addr 5 in IDLE -> next cycle ack=1, dout=15; cycle after that ack=0, dout=15.
//  Write addr 100=8'hA5 then read addr 100 on next cycle -> ack pulses twice, dout=8'hA5.
//  req every cycle during busy -> no ack; after init, write addr 3=0 then read -> 0.
//  Assert reset at cnt=30 -> ack=0, dout=0 immediately; busy 62 clks again; addr 40 reads 50.
//  RAMP_PARITY_EN: write addr 7=8'h3C with inj_perr=1, read -> perr=1; rewrite clean -> perr=0.

Source files
------------

// File: rtl/ramp_init_seq.sv
// ramp_init_seq: single-port synchronous RAM with registered read data and a
// hardware init sequencer. After reset it writes INIT_BASE+i into addresses
// 0..INIT_WORDS-1, one word per clock, and keeps busy high while it does so.
// Requests use a req/ack handshake. ack pulses for one cycle after each
// accepted request.
//
// Optional build macro: RAMP_PARITY_EN. It adds an even-parity bit per word,
// the perr output and the inj_perr input (inj_perr forces bad parity on a write).
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | sequencer fills mem[cnt]; busy=1; requests ignored
// IDLE  | normal single-port access; one request per clock
module ramp_init_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int INIT_WORDS = 62,
    parameter int INIT_BASE  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
`ifdef RAMP_PARITY_EN
    input  logic                  inj_perr,
    output logic                  perr,
`endif
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int INIT_EFF  = (INIT_WORDS < 0) ? 0 :
                               (INIT_WORDS > RAM_DEPTH) ? RAM_DEPTH : INIT_WORDS;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST =
        (INIT_EFF == 0) ? '0 : ADDR_WIDTH'(INIT_EFF - 1);
`ifdef RAMP_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  init_last;
    logic                  init_we;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [DATA_WIDTH-1:0] init_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  mem_wdata;
    logic [MEM_WIDTH-1:0]  rd_word;

    logic [MEM_WIDTH-1:0]  mem [RAM_DEPTH];

    // Zero-word init finishes on the first clock without writing anything.
    assign init_last = (INIT_EFF == 0) || (cnt == INIT_LAST);
    // Sum wraps modulo 2^DATA_WIDTH by truncation.
    assign init_data = DATA_WIDTH'(INIT_BASE) + DATA_WIDTH'(cnt);
    assign rd_word   = mem[addr];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    // Next-state logic: leave INIT on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_last) state_nxt = S_IDLE;
            S_IDLE:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // State-decoded outputs and access qualifiers.
    always_comb begin
        busy    = 1'b0;
        init_we = 1'b0;
        acc_wr  = 1'b0;
        acc_rd  = 1'b0;
        case (state)
            S_INIT: begin
                busy    = 1'b1;
                init_we = (INIT_EFF != 0);
            end
            S_IDLE: begin
                acc_wr = req && wr;
                acc_rd = req && !wr;
            end
            default: busy = 1'b1;
        endcase
    end

    // Init counter: counts only while the sequencer runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               cnt <= '0;
        else if (state == S_INIT) cnt <= cnt + 1'b1;
    end

    // Single write port shared by the sequencer and the request path.
    always_comb begin
        mem_we   = init_we || acc_wr;
        mem_addr = init_we ? cnt : addr;
        wr_data  = init_we ? init_data : din;
`ifdef RAMP_PARITY_EN
        mem_wdata = {(^wr_data) ^ (acc_wr && inj_perr), wr_data};
`else
        mem_wdata = wr_data;
`endif
    end

    // Array storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Registered handshake and read data; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack  <= 1'b0;
            dout <= '0;
`ifdef RAMP_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            ack <= acc_wr || acc_rd;
            if (acc_rd) dout <= rd_word[DATA_WIDTH-1:0];
`ifdef RAMP_PARITY_EN
            perr <= acc_rd && (rd_word[DATA_WIDTH] != ^rd_word[DATA_WIDTH-1:0]);
`endif
        end
    end

endmodule

// File: tb/tb_ramp_init_seq.sv
// Directed bench for ramp_init_seq: default instance plus a small instance
// that exercises init clamping and the wrapping init sum.
module tb_ramp_init_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [10:0] addr;
    logic [7:0]  din;
    logic        ack, busy;
    logic [7:0]  dout;

    logic        req2, wr2;
    logic [2:0]  addr2;
    logic [7:0]  din2;
    logic        ack2, busy2;
    logic [7:0]  dout2;

`ifdef RAMP_PARITY_EN
    logic inj_perr, perr, inj2, perr2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ramp_init_seq dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .din(din),
`ifdef RAMP_PARITY_EN
        .inj_perr(inj_perr), .perr(perr),
`endif
        .ack(ack), .dout(dout), .busy(busy)
    );

    ramp_init_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .INIT_WORDS(20), .INIT_BASE(250)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .wr(wr2), .addr(addr2), .din(din2),
`ifdef RAMP_PARITY_EN
        .inj_perr(inj2), .perr(perr2),
`endif
        .ack(ack2), .dout(dout2), .busy(busy2)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [10:0] addr;
        logic [7:0]  din;
        logic        exp_ack;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic w, input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        req = r; wr = w; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply2(input logic [2:0] a);
        @(negedge clk);
        req2 = 1'b1; wr2 = 1'b0; addr2 = a;
        @(posedge clk);
        #1;
        req2 = 1'b0;
    endtask

    // Counts edges until busy falls (bounded); also edge count for dut2 busy.
    task automatic count_busy(output int n, output int n2, output logic acked);
        n = 0; n2 = 0; acked = 1'b0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) acked = 1'b1;
            if (!busy2 && n2 == 0) n2 = n;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n2;
        logic acked;

        vecs[0]  = '{1'b1, 1'b0, 11'd0,    8'h00, 1'b1, 8'd10};
        vecs[1]  = '{1'b1, 1'b0, 11'd61,   8'h00, 1'b1, 8'd71};
        vecs[2]  = '{1'b1, 1'b0, 11'd5,    8'h00, 1'b1, 8'd15};
        vecs[3]  = '{1'b0, 1'b0, 11'd5,    8'h00, 1'b0, 8'd15};
        vecs[4]  = '{1'b1, 1'b1, 11'd100,  8'hA5, 1'b1, 8'd15};
        vecs[5]  = '{1'b1, 1'b0, 11'd100,  8'h00, 1'b1, 8'hA5};
        vecs[6]  = '{1'b1, 1'b0, 11'd3,    8'h00, 1'b1, 8'd13};
        vecs[7]  = '{1'b1, 1'b1, 11'd3,    8'h00, 1'b1, 8'd13};
        vecs[8]  = '{1'b1, 1'b0, 11'd3,    8'h00, 1'b1, 8'h00};
        vecs[9]  = '{1'b1, 1'b1, 11'd62,   8'h5A, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 11'd62,   8'h00, 1'b1, 8'h5A};
        vecs[11] = '{1'b0, 1'b1, 11'd62,   8'hFF, 1'b0, 8'h5A};
        vecs[12] = '{1'b1, 1'b0, 11'd30,   8'h00, 1'b1, 8'd40};
        vecs[13] = '{1'b1, 1'b1, 11'd2047, 8'hFF, 1'b1, 8'd40};
        vecs[14] = '{1'b1, 1'b0, 11'd2047, 8'h00, 1'b1, 8'hFF};
        vecs[15] = '{1'b1, 1'b0, 11'd30,   8'h00, 1'b1, 8'd40};

        reset = 1'b1;
        req = 1'b0; wr = 1'b0; addr = '0; din = '0;
        req2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
`ifdef RAMP_PARITY_EN
        inj_perr = 1'b0; inj2 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b1);
        check("reset_ack",  ack,  1'b0);
        check("reset_dout", dout, 8'h00);

        // Release with a write hammered every cycle; init must ignore it.
        @(negedge clk);
        reset = 1'b0;
        req = 1'b1; wr = 1'b1; addr = 11'd3; din = 8'hFF;
        count_busy(n, n2, acked);
        check("init_busy_clks", n, 62);
        check("init_no_ack", acked, 1'b0);
        check("init_dout_hold", dout, 8'h00);
        check("small_busy_clks", n2, 8);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_ack", i),  ack,  vecs[i].exp_ack);
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
        end
        apply(1'b0, 1'b0, 11'd0, 8'h00);
        check("idle_ack_low", ack, 1'b0);

        // Small instance: clamp to 8 words, base 250 wraps past 255.
        apply2(3'd0);
        check("small_rd0", dout2, 8'd250);
        check("small_ack", ack2, 1'b1);
        apply2(3'd5);
        check("small_rd5", dout2, 8'd255);
        apply2(3'd6);
        check("small_rd6", dout2, 8'd0);
        apply2(3'd7);
        check("small_rd7", dout2, 8'd1);

`ifdef RAMP_PARITY_EN
        apply(1'b1, 1'b0, 11'd0, 8'h00);
        check("par_init_perr", perr, 1'b0);
        @(negedge clk); inj_perr = 1'b1;
        apply(1'b1, 1'b1, 11'd7, 8'h3C);
        @(negedge clk); inj_perr = 1'b0;
        apply(1'b1, 1'b0, 11'd7, 8'h00);
        check("par_bad_perr", perr, 1'b1);
        check("par_bad_dout", dout, 8'h3C);
        apply(1'b1, 1'b1, 11'd7, 8'h3C);
        check("par_wr_perr", perr, 1'b0);
        apply(1'b1, 1'b0, 11'd7, 8'h00);
        check("par_clean_perr", perr, 1'b0);
        apply(1'b0, 1'b0, 11'd0, 8'h00);
`endif

        // Read in flight when reset asserts: dropped, no ack.
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 11'd30; reset = 1'b1;
        @(posedge clk);
        #1;
        check("drop_ack", ack, 1'b0);
        check("drop_dout", dout, 8'h00);

        // Restart init, then reset again at cnt=30.
        @(negedge clk);
        reset = 1'b0;
        acked = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (ack) acked = 1'b1;
        end
        check("mid_busy", busy, 1'b1);
        check("mid_no_ack", acked, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ack", ack, 1'b0);
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        req = 1'b0;
        count_busy(n, n2, acked);
        check("reinit_busy_clks", n, 62);

        apply(1'b1, 1'b0, 11'd40, 8'h00);
        check("reinit_rd40", dout, 8'd50);
        apply(1'b1, 1'b0, 11'd100, 8'h00);
        check("persist_rd100", dout, 8'hA5);
        apply(1'b1, 1'b0, 11'd3, 8'h00);
        check("reinit_rd3", dout, 8'd13);
        apply(1'b1, 1'b0, 11'd2047, 8'h00);
        check("persist_rd2047", dout, 8'hFF);
        apply(1'b0, 1'b0, 11'd0, 8'h00);
        check("final_ack_low", ack, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
